tmds_gearbox_10to5: RTL and testbench
=====================================

Name: tmds_gearbox_10to5

Overview:
- Upstream neighbour of the 5-bit LVDS serializer output stage.
- Accepts 10-bit TMDS symbols from the encoder through a valid/ready handshake and buffers them in a small FIFO.
- Emits each symbol as two 5-bit halves on consecutive clkLoad cycles (low half first), driving the serializer's serialData input.
- On FIFO underflow it substitutes an idle control token and flags the event, so the link never sees garbage.

Parameters:
- IDLE_SYMBOL, 10'b1101010100, token sent on underflow or while disabled (TMDS CTRL 00).
- FIFO_DEPTH, 2, symbol FIFO entries; legal values are 2 and 4 only.
- CNT_WIDTH, 16, width of the optional underflow counter.

Ports:
- clkLoad  in  1  Single clock; runs at twice the pixel rate (same clock as the serializer's clkLoad).
- resetN  in  1  Synchronous, active-low reset.
- enable  in  1  Output enable; when low, the block emits idle and does not pop.
- symbolIn  in  10  TMDS symbol; bit 0 is transmitted first.
- symbolValid  in  1  symbolIn is valid.
- symbolReady  out  1  FIFO can accept a symbol.
- serialData  out  5  Registered half-symbol to the serializer.
- phase  out  1  0 = serialData holds a low half, 1 = serialData holds a high half.
- underflow  out  1  Sticky underflow flag.
- clearUnderflow  in  1  Clears underflow (and underflowCount when the counter is compiled in).
- underflowCount  out  CNT_WIDTH  Present only with the optional feature.

Behaviour:
- Clock and reset:
  - Single clock domain clkLoad.
  - Reset is synchronous, active-low on resetN; it is sampled only at the rising edge of clkLoad.
- Reset values:
  - serialData = IDLE_SYMBOL[4:0], phase = 0, FIFO empty, underflow = 0, underflowCount = 0, internal cur = IDLE_SYMBOL.
  - symbolReady = 0 while resetN = 0.
- Handshake:
  - symbolReady = resetN && (fifoCount != FIFO_DEPTH), derived from registered state only.
  - A push occurs on an edge where symbolValid && symbolReady.
  - symbolIn must stay stable while symbolValid=1 && symbolReady=0.
- Edge with enable=1, current phase=0 (pop slot):
  - FIFO non-empty: pop the head into cur; serialData <= head[4:0].
  - FIFO empty: cur <= IDLE_SYMBOL; serialData <= IDLE_SYMBOL[4:0]; underflow <= 1.
  - phase <= 1.
- Edge with enable=1, current phase=1:
  - serialData <= cur[9:5]; phase <= 0; no pop.
- Edge with enable=0:
  - phase <= 0; serialData <= IDLE_SYMBOL[4:0]; no pop; underflow unchanged.
  - Pushes are still accepted until the FIFO is full.
- Latency:
  - Symbol pushed at edge N into an empty FIFO, with phase=0 at edge N+1: low half appears after edge N+1, high half after edge N+2.
  - There is no bypass path. A push and a pop-attempt on an empty FIFO at the same edge count as an underflow; the pushed symbol is kept for the next slot.
- Simultaneous push and pop at the same edge: fifoCount is unchanged. This is legal when full: the pop frees the slot, but ready was already 0, so no push can occur.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrapping naturally. fifoCount is 0..FIFO_DEPTH.
- Flag priority: on an edge where clearUnderflow=1 and an underflow event coincide, set wins (underflow stays 1).
- Reset asserted mid-symbol: the high half is discarded; the next output after reset release is IDLE_SYMBOL[4:0] with phase=0.
- Throughput: sustained rate is one symbol per two clocks; the producer must not average faster.

Optional Feature:
- Macro: TMDS_GEARBOX_UNDERFLOW_COUNT_EN.
- Defined:
  - underflowCount port exists; it increments by 1 on each underflow event and saturates at all-ones.
  - clearUnderflow zeroes it; if clear and an event coincide, the count becomes 1.
- Undefined: the port and counter logic are absent; underflow flag behaviour is unchanged.

Test Plan:
- Reset then idle, enable=1, no input -> serialData alternates 5'b10100 / 5'b11010, and underflow=1 after the first pop slot.
- Push 10'h2AB (symbolIn), then 10'h155 back-to-back at phase-aligned edges -> serialData sequence 5'h0B, 5'h15, 5'h15, 5'h0A, with no underflow after clearUnderflow.
- Hold symbolValid=1 with a constant producer and FIFO_DEPTH=2 -> symbolReady deasserts after 2 accepted while enable=0; with enable=1, steady 1-in-2 acceptance and fifoCount never exceeds 2.
- Pulse resetN low while phase=1 carrying 10'h3FF -> next serialData is 5'b10100, phase=0, FIFO empty, symbolReady=0 during reset.
- clearUnderflow asserted on the same edge as an empty pop slot -> underflow stays 1; with TMDS_GEARBOX_UNDERFLOW_COUNT_EN, underflowCount=1.
- With the macro defined, force 2^CNT_WIDTH+3 underflows -> underflowCount saturates at 16'hFFFF.

Source files
------------

// File: rtl/tmds_gearbox_10to5.sv
// tmds_gearbox_10to5: buffers 10-bit TMDS symbols and emits them as 5-bit halves, low half first.
// Optional underflow event counter: define TMDS_GEARBOX_UNDERFLOW_COUNT_EN.
module tmds_gearbox_10to5 #(
    parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100,
    parameter int         FIFO_DEPTH  = 2,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                 clkLoad,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic [9:0]           symbolIn,
    input  logic                 symbolValid,
    output logic                 symbolReady,
    output logic [4:0]           serialData,
    output logic                 phase,
    output logic                 underflow,
    input  logic                 clearUnderflow
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] underflowCount
`endif
);

    // Pointer width: 1 bit for depth 2, 2 bits for depth 4.
    localparam int            PW      = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic [9:0]    r_cur;
    logic [4:0]    r_data;
    logic          r_phase;
    logic          r_uflow;

    logic          w_push;
    logic          w_slot;
    logic          w_pop;
    logic          w_event;

    // Ready depends only on reset and registered occupancy, never on this cycle's pop.
    assign symbolReady = resetN && (r_count != DEPTH_C);
    assign w_push      = symbolValid && symbolReady;
    assign w_slot      = enable && !r_phase;
    assign w_pop       = w_slot && (r_count != '0);
    assign w_event     = w_slot && (r_count == '0);

    assign serialData  = r_data;
    assign phase       = r_phase;
    assign underflow   = r_uflow;

    // Symbol storage; writes are gated by ready, which is low during reset.
    always_ff @(posedge clkLoad) begin
        if (w_push) begin
            r_mem[r_wptr] <= symbolIn;
        end
    end

    // FIFO pointers and occupancy; pointers wrap at the power-of-two depth.
    always_ff @(posedge clkLoad) begin
        if (!resetN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Half-symbol sequencer: low half on the pop slot, high half on the next edge.
    always_ff @(posedge clkLoad) begin
        if (!resetN) begin
            r_data  <= IDLE_SYMBOL[4:0];
            r_phase <= 1'b0;
            r_cur   <= IDLE_SYMBOL;
        end else if (!enable) begin
            r_data  <= IDLE_SYMBOL[4:0];
            r_phase <= 1'b0;
        end else if (!r_phase) begin
            r_phase <= 1'b1;
            if (w_pop) begin
                r_cur  <= r_mem[r_rptr];
                r_data <= r_mem[r_rptr][4:0];
            end else begin
                r_cur  <= IDLE_SYMBOL;
                r_data <= IDLE_SYMBOL[4:0];
            end
        end else begin
            r_phase <= 1'b0;
            r_data  <= r_cur[9:5];
        end
    end

    // Sticky underflow flag; a new event beats a coincident clear.
    always_ff @(posedge clkLoad) begin
        if (!resetN) begin
            r_uflow <= 1'b0;
        end else if (w_event) begin
            r_uflow <= 1'b1;
        end else if (clearUnderflow) begin
            r_uflow <= 1'b0;
        end
    end

`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    logic [CNT_WIDTH-1:0] r_ucnt;

    assign underflowCount = r_ucnt;

    // Saturating event counter; clear with a coincident event leaves exactly one.
    always_ff @(posedge clkLoad) begin
        if (!resetN) begin
            r_ucnt <= '0;
        end else if (w_event) begin
            if (clearUnderflow) begin
                r_ucnt <= CNT_WIDTH'(1);
            end else if (r_ucnt != '1) begin
                r_ucnt <= r_ucnt + 1'b1;
            end
        end else if (clearUnderflow) begin
            r_ucnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_gearbox_10to5.sv
// tb_tmds_gearbox_10to5: queue-based reference model feeding a scoreboard,
// monitor compares DUT outputs on each falling edge.
module tb_tmds_gearbox_10to5;

    localparam logic [9:0] IDLE  = 10'b1101010100;
    localparam int         DEPTH = 2;
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    localparam int         CW    = 8;
`else
    localparam int         CW    = 16;
`endif
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct {
        logic [4:0]    sd;
        logic          ph;
        logic          uf;
        logic          nf;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          enable = 1'b0;
    logic [9:0]    symbolIn = '0;
    logic          symbolValid = 1'b0;
    logic          symbolReady;
    logic [4:0]    serialData;
    logic          phase;
    logic          underflow;
    logic          clearUnderflow = 1'b0;
    logic [CW-1:0] underflowCount;

    int checks = 0;
    int errors = 0;

    exp_t          expq[$];
    logic [9:0]    mq[$];
    logic          mph = 1'b0;
    logic [9:0]    mcur = IDLE;
    logic [4:0]    msd = IDLE[4:0];
    logic          muf = 1'b0;
    logic [CW-1:0] mcnt = '0;
    logic          pushed = 1'b0;

    always #5 clk = ~clk;

    tmds_gearbox_10to5 #(
        .IDLE_SYMBOL(IDLE),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .clkLoad(clk),
        .resetN(resetN),
        .enable(enable),
        .symbolIn(symbolIn),
        .symbolValid(symbolValid),
        .symbolReady(symbolReady),
        .serialData(serialData),
        .phase(phase),
        .underflow(underflow),
        .clearUnderflow(clearUnderflow)
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
        ,
        .underflowCount(underflowCount)
`endif
    );

`ifndef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    assign underflowCount = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: apply inputs, advance the reference model, queue the expectation.
    task automatic step(input logic rn, input logic en, input logic v,
                        input logic [9:0] s, input logic clr);
        exp_t e;
        logic rdy;
        logic ev;
        resetN = rn;
        enable = en;
        symbolValid = v;
        symbolIn = s;
        clearUnderflow = clr;
        if (!rn) begin
            mq.delete();
            mph = 1'b0;
            mcur = IDLE;
            msd = IDLE[4:0];
            muf = 1'b0;
            mcnt = '0;
            pushed = 1'b0;
        end else begin
            rdy = (mq.size() != DEPTH);
            ev = 1'b0;
            if (!en) begin
                mph = 1'b0;
                msd = IDLE[4:0];
            end else if (!mph) begin
                if (mq.size() != 0) begin
                    mcur = mq.pop_front();
                end else begin
                    mcur = IDLE;
                    ev = 1'b1;
                end
                msd = mcur[4:0];
                mph = 1'b1;
            end else begin
                msd = mcur[9:5];
                mph = 1'b0;
            end
            if (ev) muf = 1'b1;
            else if (clr) muf = 1'b0;
            if (ev) mcnt = clr ? CW'(1) : ((mcnt == CMAX) ? CMAX : mcnt + 1'b1);
            else if (clr) mcnt = '0;
            pushed = v && rdy;
            if (pushed) mq.push_back(s);
        end
        e.sd = msd;
        e.ph = mph;
        e.uf = muf;
        e.nf = (mq.size() != DEPTH);
        e.cnt = mcnt;
        @(posedge clk);
        expq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 10'h0, 1'b0);
    endtask

    task automatic align(input logic want);
        for (int i = 0; i < 2 && mph != want; i++) step(1'b1, 1'b1, 1'b0, 10'h0, 1'b0);
    endtask

    // Scoreboard monitor: one expectation per edge, sampled mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("serialData", 32'(serialData), 32'(e.sd));
            chk("phase", 32'(phase), 32'(e.ph));
            chk("underflow", 32'(underflow), 32'(e.uf));
            chk("symbolReady", 32'(symbolReady), resetN ? 32'(e.nf) : 32'd0);
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
            chk("underflowCount", 32'(underflowCount), 32'(e.cnt));
`endif
        end
    end

    initial begin : stim
        logic       hv;
        logic [9:0] hs;
        logic       en;
        logic       clr;
        logic       rn;

        // Reset, then idle with no input: idle halves alternate, underflow sets.
        repeat (3) step(1'b0, 1'b1, 1'b1, 10'h3C3, 1'b0);
        idle(6);

        // Two symbols back to back after a clear: 0B,15,15,0A.
        align(1'b1);
        step(1'b1, 1'b1, 1'b1, 10'h2AB, 1'b1);
        step(1'b1, 1'b1, 1'b1, 10'h155, 1'b0);
        idle(4);

        // Constant producer: fills while disabled, then 1-in-2 acceptance.
        repeat (4) step(1'b1, 1'b0, 1'b1, 10'h0F0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 10'h0F0, 1'b0);
        idle(6);

        // Reset pulse while the high half of 3FF is pending.
        align(1'b1);
        step(1'b1, 1'b1, 1'b1, 10'h3FF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 10'h3FF, 1'b0);
        idle(3);

        // Clear coinciding with an empty pop slot: set wins.
        idle(4);
        align(1'b0);
        step(1'b1, 1'b1, 1'b0, 10'h0, 1'b1);
        idle(2);

`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
        // Saturate the counter with 2^CW + 3 underflow events.
        step(1'b1, 1'b1, 1'b0, 10'h0, 1'b1);
        align(1'b0);
        for (int i = 0; i < 2 * ((1 << CW) + 3); i++) step(1'b1, 1'b1, 1'b0, 10'h0, 1'b0);
`endif

        // Randomized traffic; a stalled symbol stays put until accepted.
        hv = 1'b0;
        hs = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hv || pushed) begin
                hv = ($urandom_range(0, 2) != 0);
                hs = 10'($urandom);
            end
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            rn  = ($urandom_range(0, 199) != 0);
            step(rn, en, hv, hs, clr);
        end

        symbolValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
